// File: rtl/mips_hazard_pkg.sv
// Shared constants and types for the MIPS hazard/forwarding control block.
package mips_hazard_pkg;

  // Default register address width (32 architectural registers).
  localparam int REG_AW_DEF = 5;

  // Operand select codes for the EX-stage forwarding muxes.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Destination info carried down the shadow pipeline for one stage.
  typedef struct packed {
    logic [REG_AW_DEF-1:0] dest;
    logic                  wr;
    logic                  load;
  } stage_entry_t;

endpackage

// File: rtl/hazard_reg_match.sv
// Source/destination register comparator: hits when a stage writes a
// non-zero register equal to the source. Register 0 never hits.
module hazard_reg_match
  import mips_hazard_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dest,
  input  logic          dest_wr,
  output logic          hit
);

  assign hit = dest_wr && (dest != '0) && (src == dest);

endmodule

// File: rtl/mips_hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// Keeps a shadow copy of destination info for EX/MEM/WB and decodes the
// forwarding selects, stall and bubble combinationally from it.
// Optional feature: define HAZ_PERF_CNT_EN to build a saturating stall counter.
module mips_hazard_fwd_unit
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              pipe_flush,
  output logic [1:0]        fwd_ex_rs,
  output logic [1:0]        fwd_ex_rt,
  output logic              fwd_id_rs,
  output logic              fwd_id_rt,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_entry_t      ex_q;
  stage_entry_t      mem_q;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  logic [REG_AW-1:0] wb_dest_q;
  logic              wb_wr_q;
  logic              ex_capture;

  // ID only advances into EX when it is real, not held and not squashed.
  assign ex_capture = id_valid && !stall && !pipe_flush;

  // Shadow pipeline: ID -> EX -> MEM -> WB, bubbles enter EX when ID cannot.
  // NOTE: non-blocking assignments let every stage read the old value of the
  // stage before it, so the shift happens in one edge without ordering issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      wb_dest_q <= '0;
      wb_wr_q   <= 1'b0;
    end else begin
      wb_dest_q <= mem_q.dest;
      wb_wr_q   <= mem_q.wr;
      mem_q     <= ex_q;
      if (ex_capture) begin
        ex_q.dest <= id_dest;
        ex_q.wr   <= id_reg_write;
        ex_q.load <= id_mem_read;
        ex_rs_q   <= id_rs;
        ex_rt_q   <= id_rt;
      end else begin
        ex_q    <= '0;
        ex_rs_q <= '0;
        ex_rt_q <= '0;
      end
    end
  end

  // Register comparisons, one per source/stage pair.
  logic mem_hit_ex_rs, mem_hit_ex_rt, wb_hit_ex_rs, wb_hit_ex_rt;
  logic ex_hit_id_rs, ex_hit_id_rt, mem_hit_id_rs, mem_hit_id_rt;

  hazard_reg_match #(.AW(REG_AW)) u_mem_ex_rs (.src(ex_rs_q), .dest(mem_q.dest), .dest_wr(mem_q.wr), .hit(mem_hit_ex_rs));
  hazard_reg_match #(.AW(REG_AW)) u_mem_ex_rt (.src(ex_rt_q), .dest(mem_q.dest), .dest_wr(mem_q.wr), .hit(mem_hit_ex_rt));
  hazard_reg_match #(.AW(REG_AW)) u_wb_ex_rs  (.src(ex_rs_q), .dest(wb_dest_q),  .dest_wr(wb_wr_q),  .hit(wb_hit_ex_rs));
  hazard_reg_match #(.AW(REG_AW)) u_wb_ex_rt  (.src(ex_rt_q), .dest(wb_dest_q),  .dest_wr(wb_wr_q),  .hit(wb_hit_ex_rt));
  hazard_reg_match #(.AW(REG_AW)) u_ex_id_rs  (.src(id_rs),   .dest(ex_q.dest),  .dest_wr(ex_q.wr),  .hit(ex_hit_id_rs));
  hazard_reg_match #(.AW(REG_AW)) u_ex_id_rt  (.src(id_rt),   .dest(ex_q.dest),  .dest_wr(ex_q.wr),  .hit(ex_hit_id_rt));
  hazard_reg_match #(.AW(REG_AW)) u_mem_id_rs (.src(id_rs),   .dest(mem_q.dest), .dest_wr(mem_q.wr), .hit(mem_hit_id_rs));
  hazard_reg_match #(.AW(REG_AW)) u_mem_id_rt (.src(id_rt),   .dest(mem_q.dest), .dest_wr(mem_q.wr), .hit(mem_hit_id_rt));

  // EX operand selects: MEM wins over WB; a load in MEM has no data yet.
  // NOTE: defaults first so every path assigns the outputs and no latch forms.
  always_comb begin
    fwd_ex_rs = FWD_NONE;
    fwd_ex_rt = FWD_NONE;
    if (mem_hit_ex_rs && !mem_q.load) fwd_ex_rs = FWD_MEM;
    else if (wb_hit_ex_rs)            fwd_ex_rs = FWD_WB;
    if (mem_hit_ex_rt && !mem_q.load) fwd_ex_rt = FWD_MEM;
    else if (wb_hit_ex_rt)            fwd_ex_rt = FWD_WB;
  end

  // Branch operands compared in ID take an ALU result sitting in MEM.
  assign fwd_id_rs = id_is_branch && mem_hit_id_rs && !mem_q.load;
  assign fwd_id_rt = id_is_branch && mem_hit_id_rt && !mem_q.load;

  // Stall decode: only sources the ID instruction really reads count.
  logic ex_dep, mem_dep, haz_load_use, haz_br_alu, haz_br_load;

  assign ex_dep       = (ex_hit_id_rs && id_uses_rs) || (ex_hit_id_rt && id_uses_rt);
  assign mem_dep      = (mem_hit_id_rs && id_uses_rs) || (mem_hit_id_rt && id_uses_rt);
  assign haz_load_use = ex_q.load && ex_dep;
  assign haz_br_alu   = id_is_branch && !ex_q.load && ex_dep;
  assign haz_br_load  = id_is_branch && mem_q.load && mem_dep;
  assign stall        = id_valid && (haz_load_use || haz_br_alu || haz_br_load);
  assign bubble       = stall || pipe_flush;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_fwd_unit.sv
// Self-checking bench for mips_hazard_fwd_unit. Each cycle's expected
// outputs are queued when the ID stimulus is driven and compared on the
// following falling edge by a scoreboard monitor.
module tb_mips_hazard_fwd_unit;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_MEM  = 2'b01;
  localparam logic [1:0] F_WB   = 2'b10;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_branch;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_reg_write, id_mem_read, pipe_flush;
  logic [1:0]  fwd_ex_rs, fwd_ex_rt;
  logic        fwd_id_rs, fwd_id_rt, stall, bubble;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] ex_rs;
    logic [1:0] ex_rt;
    logic       id_rs;
    logic       id_rt;
    logic       stall;
    logic       bubble;
  } exp_t;

  exp_t exp_q[$];

  mips_hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .pipe_flush(pipe_flush),
    .fwd_ex_rs(fwd_ex_rs), .fwd_ex_rt(fwd_ex_rt), .fwd_id_rs(fwd_id_rs),
    .fwd_id_rt(fwd_id_rt), .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard: one queued expectation per stimulus cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total += 6;
      if (fwd_ex_rs !== e.ex_rs) begin bad++; $display("FAIL %s fwd_ex_rs got=%b want=%b", e.name, fwd_ex_rs, e.ex_rs); end
      if (fwd_ex_rt !== e.ex_rt) begin bad++; $display("FAIL %s fwd_ex_rt got=%b want=%b", e.name, fwd_ex_rt, e.ex_rt); end
      if (fwd_id_rs !== e.id_rs) begin bad++; $display("FAIL %s fwd_id_rs got=%b want=%b", e.name, fwd_id_rs, e.id_rs); end
      if (fwd_id_rt !== e.id_rt) begin bad++; $display("FAIL %s fwd_id_rt got=%b want=%b", e.name, fwd_id_rt, e.id_rt); end
      if (stall !== e.stall)     begin bad++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
      if (bubble !== e.bubble)   begin bad++; $display("FAIL %s bubble got=%b want=%b", e.name, bubble, e.bubble); end
    end
  end

  // ---- stimulus helpers ----
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic br,
                        input logic [4:0] dst, input logic wr, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_dest = dst; id_reg_write = wr; id_mem_read = mr;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    set_id(1'b1, s, t, 1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [4:0] d, input logic [4:0] base);
    set_id(1'b1, base, d, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b1);
  endtask

  task automatic beq(input logic [4:0] s, input logic [4:0] t);
    set_id(1'b1, s, t, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic push(input string nm, input logic [1:0] ers, input logic [1:0] ert,
                      input logic eirs, input logic eirt, input logic est, input logic ebu);
    exp_t e;
    e.name = nm; e.ex_rs = ers; e.ex_rt = ert; e.id_rs = eirs;
    e.id_rt = eirt; e.stall = est; e.bubble = ebu;
    exp_q.push_back(e);
  endtask

  // Queue expectations for the currently driven ID inputs, move to next cycle.
  task automatic advance(input string nm, input logic [1:0] ers, input logic [1:0] ert,
                         input logic eirs, input logic eirt, input logic est, input logic ebu);
    push(nm, ers, ert, eirs, eirt, est, ebu);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string nm);
    advance(nm, F_NONE, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Empty the shadow pipeline without checking.
  task automatic drain();
    nop();
    pipe_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    pipe_flush = 1'b0;
    beq(5'd5, 5'd6);
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (fwd_ex_rs !== F_NONE) begin bad++; $display("FAIL reset fwd_ex_rs got=%b want=00", fwd_ex_rs); end
    if (fwd_ex_rt !== F_NONE) begin bad++; $display("FAIL reset fwd_ex_rt got=%b want=00", fwd_ex_rt); end
    if (fwd_id_rs !== 1'b0)   begin bad++; $display("FAIL reset fwd_id_rs got=%b want=0", fwd_id_rs); end
    if (stall !== 1'b0)       begin bad++; $display("FAIL reset stall got=%b want=0", stall); end
    if (bubble !== 1'b0)      begin bad++; $display("FAIL reset bubble got=%b want=0", bubble); end
    if (stall_cnt !== 32'd0)  begin bad++; $display("FAIL reset stall_cnt got=%0d want=0", stall_cnt); end
    nop();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_fwd();
    drain();
    alu(5'd3, 5'd1, 5'd2);   quiet("t1_c0");
    alu(5'd4, 5'd3, 5'd5);   quiet("t1_c1");
    alu(5'd12, 5'd3, 5'd13); advance("t1_mem_fwd", F_MEM, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();                   advance("t1_wb_fwd", F_WB, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_use();
    drain();
    load(5'd2, 5'd0);      quiet("t2_c0");
    alu(5'd6, 5'd2, 5'd7); advance("t2_stall", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
                           quiet("t2_release");
    nop();                 advance("t2_wb_fwd", F_WB, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_branch();
    logic [31:0] want;
    do_reset();
    load(5'd8, 5'd0); quiet("t3_c0");
    beq(5'd8, 5'd9);  advance("t3_stall_a", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
                      advance("t3_stall_c", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
                      quiet("t3_release");
    want = PERF ? 32'd2 : 32'd0;
    total++;
    if (stall_cnt !== want) begin bad++; $display("FAIL t3_stall_cnt got=%0d want=%0d", stall_cnt, want); end
  endtask

  task automatic test_alu_branch();
    drain();
    alu(5'd10, 5'd1, 5'd1); quiet("t4_c0");
    beq(5'd10, 5'd0);       advance("t4_stall", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
                            advance("t4_id_fwd", F_NONE, F_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();                  advance("t4_wb_fwd", F_WB, F_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_reg();
    drain();
    alu(5'd0, 5'd1, 5'd1);  quiet("t5_wr0");
    load(5'd0, 5'd0);       quiet("t5_lw0");
    beq(5'd0, 5'd0);        quiet("t5_beq0");
    alu(5'd15, 5'd0, 5'd0); quiet("t5_use0");
    nop();                  quiet("t5_ex_use0");
  endtask

  task automatic test_mem_over_wb();
    drain();
    alu(5'd11, 5'd1, 5'd1);   quiet("t5b_c0");
    alu(5'd11, 5'd1, 5'd1);   quiet("t5b_c1");
    alu(5'd16, 5'd11, 5'd11); quiet("t5b_c2");
    nop();                    advance("t5b_prio", F_MEM, F_MEM, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    drain();
    alu(5'd17, 5'd1, 5'd1);
    pipe_flush = 1'b1;       advance("t7_flush", F_NONE, F_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    pipe_flush = 1'b0;
    alu(5'd18, 5'd17, 5'd1); quiet("t7_c1");
    nop();                   quiet("t7_no_fwd");
    drain();
    load(5'd19, 5'd0);       quiet("t7b_c0");
    alu(5'd20, 5'd19, 5'd1);
    pipe_flush = 1'b1;       advance("t7b_both", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    pipe_flush = 1'b0;       quiet("t7b_after");
  endtask

  task automatic test_reset_mid_stall();
    drain();
    load(5'd8, 5'd0); quiet("t6_c0");
    beq(5'd8, 5'd9);  advance("t6_stall_a", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    push("t6_stall_c", F_NONE, F_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (stall !== 1'b0)      begin bad++; $display("FAIL t6_async stall got=%b want=0", stall); end
    if (bubble !== 1'b0)     begin bad++; $display("FAIL t6_async bubble got=%b want=0", bubble); end
    if (fwd_ex_rs !== F_NONE) begin bad++; $display("FAIL t6_async fwd_ex_rs got=%b want=00", fwd_ex_rs); end
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL t6_async stall_cnt got=%0d want=0", stall_cnt); end
    nop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet("t6_after");
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL t6_after stall_cnt got=%0d want=0", stall_cnt); end
  endtask

  initial begin
    nop();
    pipe_flush = 1'b0;
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_zero_reg();
    test_mem_over_wb();
    test_flush();
    test_reset_mid_stall();
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
